// File: rtl/sync_true_dual_port_ram_be_pipe.sv
// Single-clock true dual-port RAM with byte-lane writes, registered outputs and
// write-write collision flag. Define SYNC_TDP_RAM_OUT_PIPE_EN for a second output stage (latency 2).
module sync_true_dual_port_ram_be_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en_a,
    input  logic                       we_a,
    input  logic [DATA_W/BYTE_W-1:0]   be_a,
    input  logic [ADDR_W-1:0]          addr_a,
    input  logic [DATA_W-1:0]          data_a,
    output logic [DATA_W-1:0]          q_a,
    output logic                       valid_a,
    input  logic                       en_b,
    input  logic                       we_b,
    input  logic [DATA_W/BYTE_W-1:0]   be_b,
    input  logic [ADDR_W-1:0]          addr_b,
    input  logic [DATA_W-1:0]          data_b,
    output logic [DATA_W-1:0]          q_b,
    output logic                       valid_b,
    output logic                       collision
);
    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_W;

    if (DATA_W % BYTE_W != 0) begin : g_bad_width
        $error("DATA_W must be a multiple of BYTE_W");
    end
    if (RDW_MODE != 0 && RDW_MODE != 1) begin : g_bad_rdw
        $error("RDW_MODE must be 0 or 1");
    end

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] new_word,
                                                input logic [NB-1:0]     lanes);
        merge = old_word;
        for (int i = 0; i < NB; i++) begin
            if (lanes[i]) merge[i*BYTE_W +: BYTE_W] = new_word[i*BYTE_W +: BYTE_W];
        end
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_a, wr_b, same_addr;
    logic [DATA_W-1:0] old_a, old_b, rd_a, rd_b;
    logic [DATA_W-1:0] q1_a, q1_b;
    logic              v1_a, v1_b, coll1;

    // A write with no lanes enabled behaves as a plain read
    assign wr_a      = en_a & we_a & (|be_a);
    assign wr_b      = en_b & we_b & (|be_b);
    assign same_addr = (addr_a == addr_b);
    assign old_a     = mem[addr_a];
    assign old_b     = mem[addr_b];
    assign rd_a      = (wr_a && RDW_MODE == 0) ? merge(old_a, data_a, be_a) : old_a;
    assign rd_b      = (wr_b && RDW_MODE == 0) ? merge(old_b, data_b, be_b) : old_b;

    // Port A owns every lane both ports write at the same address
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i] && !(wr_a && be_a[i] && same_addr))
                    mem[addr_b][i*BYTE_W +: BYTE_W] <= data_b[i*BYTE_W +: BYTE_W];
                if (wr_a && be_a[i])
                    mem[addr_a][i*BYTE_W +: BYTE_W] <= data_a[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q1_a  <= '0;
            q1_b  <= '0;
            v1_a  <= 1'b0;
            v1_b  <= 1'b0;
            coll1 <= 1'b0;
        end else begin
            v1_a  <= en_a;
            v1_b  <= en_b;
            coll1 <= wr_a & wr_b & same_addr;
            if (en_a) q1_a <= rd_a;
            if (en_b) q1_b <= rd_b;
        end
    end

`ifdef SYNC_TDP_RAM_OUT_PIPE_EN
    logic [DATA_W-1:0] q2_a, q2_b;
    logic              v2_a, v2_b, coll2;

    // Stage 2 data only moves when stage 1 carries a fresh word
    always_ff @(posedge clk) begin
        if (rst) begin
            q2_a  <= '0;
            q2_b  <= '0;
            v2_a  <= 1'b0;
            v2_b  <= 1'b0;
            coll2 <= 1'b0;
        end else begin
            v2_a  <= v1_a;
            v2_b  <= v1_b;
            coll2 <= coll1;
            if (v1_a) q2_a <= q1_a;
            if (v1_b) q2_b <= q1_b;
        end
    end

    assign q_a       = q2_a;
    assign q_b       = q2_b;
    assign valid_a   = v2_a;
    assign valid_b   = v2_b;
    assign collision = coll2;
`else
    assign q_a       = q1_a;
    assign q_b       = q1_b;
    assign valid_a   = v1_a;
    assign valid_b   = v1_b;
    assign collision = coll1;
`endif

endmodule

// File: tb/tb_sync_true_dual_port_ram_be_pipe.sv
// Scoreboard bench for sync_true_dual_port_ram_be_pipe: a reference memory model
// predicts each port's read word and the collision flag at issue time.
module tb_sync_true_dual_port_ram_be_pipe;
    parameter int RDW = 0;
`ifdef SYNC_TDP_RAM_OUT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [3:0]  be_a = '0, be_b = '0;
    logic [9:0]  addr_a = '0, addr_b = '0;
    logic [31:0] data_a = '0, data_b = '0;
    logic [31:0] q_a, q_b;
    logic        valid_a, valid_b, collision;

    sync_true_dual_port_ram_be_pipe #(
        .DATA_W(32), .ADDR_W(10), .BYTE_W(8), .RDW_MODE(RDW)
    ) dut (
        .clk(clk), .rst(rst),
        .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(q_a), .valid_a(valid_a),
        .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(q_b), .valid_b(valid_b),
        .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_a[$];
    sb_t         sb_b[$];
    int          sb_c[$];
    logic [31:0] mm [1024];
    logic [31:0] last_a = '0, last_b = '0;
    int          ec = 0;
    int          n_chk = 0, n_fail = 0;
    bit          run_mon = 1'b0;

    always @(posedge clk) ec++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        merge = o;
        for (int i = 0; i < 4; i++) if (be[i]) merge[i*8 +: 8] = n[i*8 +: 8];
    endfunction

    // Outputs of edge ec are sampled on the following falling edge
    always @(negedge clk) begin
        if (run_mon) begin
            if (sb_a.size() > 0 && sb_a[0].due == ec) begin
                chk("valid_a", {31'b0, valid_a}, 32'd1);
                chk("q_a", q_a, sb_a[0].data);
                last_a = sb_a[0].data;
                void'(sb_a.pop_front());
            end else begin
                chk("valid_a_idle", {31'b0, valid_a}, 32'd0);
                chk("q_a_hold", q_a, last_a);
            end
            if (sb_b.size() > 0 && sb_b[0].due == ec) begin
                chk("valid_b", {31'b0, valid_b}, 32'd1);
                chk("q_b", q_b, sb_b[0].data);
                last_b = sb_b[0].data;
                void'(sb_b.pop_front());
            end else begin
                chk("valid_b_idle", {31'b0, valid_b}, 32'd0);
                chk("q_b_hold", q_b, last_b);
            end
            if (sb_c.size() > 0 && sb_c[0] == ec) begin
                chk("collision", {31'b0, collision}, 32'd1);
                void'(sb_c.pop_front());
            end else begin
                chk("collision_idle", {31'b0, collision}, 32'd0);
            end
        end
    end

    task automatic drive(input logic ea, input logic wa, input logic [3:0] ba,
                         input logic [9:0] aa, input logic [31:0] da,
                         input logic eb, input logic wb, input logic [3:0] bb,
                         input logic [9:0] ab, input logic [31:0] db);
        logic [31:0] oa, ob, ma, mb;
        logic        wra, wrb;
        @(negedge clk);
        #1;
        en_a = ea; we_a = wa; be_a = ba; addr_a = aa; data_a = da;
        en_b = eb; we_b = wb; be_b = bb; addr_b = ab; data_b = db;
        wra = ea & wa & (|ba);
        wrb = eb & wb & (|bb);
        oa  = mm[aa];
        ob  = mm[ab];
        ma  = merge(oa, da, ba);
        mb  = merge(ob, db, bb);
        if (ea) sb_a.push_back('{ec + LAT, (wra && RDW == 0) ? ma : oa});
        if (eb) sb_b.push_back('{ec + LAT, (wrb && RDW == 0) ? mb : ob});
        if (wra && wrb && aa == ab) sb_c.push_back(ec + LAT);
        if (wrb) mm[ab] = mb;
        if (wra) mm[aa] = merge(mm[aa], da, ba);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 4'h0, 10'd0, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
    endtask

    // Reset with traffic on both ports: nothing written, in-flight reads dropped
    task automatic reset_with_traffic(input logic [9:0] a);
        @(negedge clk);
        #1;
        rst = 1'b1;
        en_a = 1'b1; we_a = 1'b1; be_a = 4'hF; addr_a = a; data_a = 32'hDEAD_BEEF;
        en_b = 1'b1; we_b = 1'b0; be_b = 4'h0; addr_b = a; data_b = 32'h0;
        sb_a.delete(); sb_b.delete(); sb_c.delete();
        last_a = '0; last_b = '0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        run_mon = 1'b1;

        // Preload addresses 0..15 with known words
        for (int i = 0; i < 16; i++)
            drive(1, 1, 4'hF, 10'(i), 32'h0101_0101 * (i + 1), 0, 0, 4'h0, 10'd0, 32'h0);
        drive(1, 0, 4'h0, 10'd9, 32'h0, 1, 0, 4'h0, 10'd4, 32'h0);
        idle(2);

        reset_with_traffic(10'd9);
        idle(2);
        drive(1, 0, 4'h0, 10'd9, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
        idle(2);

        drive(1, 1, 4'hF, 10'd5, 32'hAABB_CCDD, 0, 0, 4'h0, 10'd0, 32'h0);
        drive(1, 1, 4'h5, 10'd5, 32'h1122_3344, 0, 0, 4'h0, 10'd0, 32'h0);
        drive(0, 0, 4'h0, 10'd0, 32'h0, 1, 0, 4'h0, 10'd5, 32'h0);
        idle(2);

        drive(1, 1, 4'hF, 10'd7, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
        drive(1, 1, 4'hF, 10'd7, 32'hFFFF_FFFF, 1, 0, 4'h0, 10'd7, 32'h0);
        drive(0, 0, 4'h0, 10'd0, 32'h0, 1, 0, 4'h0, 10'd7, 32'h0);
        idle(2);

        drive(1, 1, 4'h3, 10'd3, 32'h1234_5678, 1, 1, 4'hF, 10'd3, 32'h9ABC_DEF0);
        drive(1, 0, 4'h0, 10'd3, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
        idle(3);

        drive(1, 0, 4'h0, 10'd9, 32'h0, 0, 0, 4'h0, 10'd0, 32'h0);
        idle(3);
        for (int i = 0; i < 16; i++)
            drive(1, 0, 4'h0, 10'(i), 32'h0, 1, 0, 4'h0, 10'(i), 32'h0);
        idle(2);

        // Mixed random traffic over the preloaded region, collisions included
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  10'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                  10'($urandom_range(0, 15)), $urandom);
        idle(LAT + 3);

        chk("sb_a_drained", 32'(sb_a.size()), 32'd0);
        chk("sb_b_drained", 32'(sb_b.size()), 32'd0);
        chk("sb_c_drained", 32'(sb_c.size()), 32'd0);
        run_mon = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
